// File: rtl/csum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csum_pkg
// Brief    : Shared types and end-around-carry helpers for the checksum stream.
// Revision : 1.0
// ============================================================================
package csum_pkg;

    typedef logic [15:0] csum_t;

    typedef struct packed {
        logic  valid;
        logic  first;
        logic  last;
        logic  phase;
        csum_t seed;
    } side_t;

    function automatic csum_t ocadd16(input csum_t a, input csum_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic csum_t bswap16(input csum_t a);
        return {a[7:0], a[15:8]};
    endfunction

    function automatic int csum_latency(input int bytes);
        int t;
        t = 0;
        while ((1 << t) < (bytes / 2)) t++;
        return t + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csum_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : csum_stream_if
// Brief    : Beat stream in, checksum result out, for csum_stream.
// Revision : 1.0
// ============================================================================
interface csum_stream_if #(
    parameter int BYTES = 20
);
    localparam int NBW = $clog2(BYTES) + 1;

    logic [7:0]     data_i [BYTES];
    logic [NBW-1:0] nbytes_i;
    logic           valid_i;
    logic           last_i;
    logic [15:0]    seed_i;
    logic [15:0]    csum_o;
    logic           csum_valid_o;

    modport master (
        output data_i, nbytes_i, valid_i, last_i, seed_i,
        input  csum_o, csum_valid_o
    );

    modport slave (
        input  data_i, nbytes_i, valid_i, last_i, seed_i,
        output csum_o, csum_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/csum_tree.sv
`default_nettype none
// ============================================================================
// Module   : csum_tree
// Brief    : Pipelined end-around-carry adder tree, one register per level,
//            with the packet sideband delayed alongside the data.
// Revision : 1.0
// ============================================================================
module csum_tree
    import csum_pkg::*;
#(
    parameter int WORDS = 10
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire csum_t words [WORDS],
    input  wire side_t side_in,
    output csum_t      sum,
    output side_t      side_out
);
    localparam int DEPTH  = $clog2(WORDS);
    localparam int LEAVES = 1 << DEPTH;

    generate
        if (DEPTH == 0) begin : g_pass
            assign sum      = words[0];
            assign side_out = side_in;
        end else begin : g_tree
            csum_t leaf  [LEAVES];
            csum_t r_lvl [DEPTH][LEAVES/2];
            side_t r_sb  [DEPTH];

            // Pad to a power of two with zeros, which are neutral for the sum.
            always_comb begin
                for (int j = 0; j < LEAVES; j++) leaf[j] = '0;
                for (int j = 0; j < WORDS; j++)  leaf[j] = words[j];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_sb[k] <= '0;
                        for (int j = 0; j < LEAVES/2; j++) r_lvl[k][j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < LEAVES/2; j++)
                        r_lvl[0][j] <= ocadd16(leaf[2*j], leaf[2*j+1]);
                    for (int k = 1; k < DEPTH; k++)
                        for (int j = 0; j < (LEAVES >> (k+1)); j++)
                            r_lvl[k][j] <= ocadd16(r_lvl[k-1][2*j], r_lvl[k-1][2*j+1]);
                    r_sb[0] <= side_in;
                    for (int k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
                end
            end

            assign sum      = r_lvl[DEPTH-1][0];
            assign side_out = r_sb[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/csum_stream.sv
`default_nettype none
// ============================================================================
// Module   : csum_stream
// Brief    : Streaming 16-bit ones-complement checksum, BYTES lanes per beat.
//            Define CSUM_ZERO_SUBST_EN to emit 16'hFFFF in place of 16'h0000.
// Revision : 1.0
// ============================================================================
module csum_stream
    import csum_pkg::*;
#(
    parameter int BYTES = 20
) (
    input  wire logic    CLK_i,
    input  wire logic    reset_n_i,
    csum_stream_if.slave bus
);
    localparam int WORDS = BYTES / 2;
    localparam int NBW   = $clog2(BYTES) + 1;

    logic [7:0] w_lane  [BYTES];
    csum_t      w_words [WORDS];
    csum_t      r_words [WORDS];
    side_t      r_side;
    logic       r_phase;
    logic       r_in_pkt;
    logic       w_first;
    logic       w_phase_in;

    csum_t      w_sum;
    side_t      w_side;
    csum_t      w_beat;
    csum_t      r_acc;
    logic       r_acc_done;
    csum_t      w_csum;

    assign w_first    = !r_in_pkt;
    assign w_phase_in = w_first ? 1'b0 : r_phase;

    always_comb begin
        for (int i = 0; i < BYTES; i++)
            w_lane[i] = (NBW'(i) < bus.nbytes_i) ? bus.data_i[i] : 8'h00;
        for (int j = 0; j < WORDS; j++)
            w_words[j] = {w_lane[2*j], w_lane[2*j+1]};
    end

    always_ff @(posedge CLK_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int j = 0; j < WORDS; j++) r_words[j] <= '0;
            r_side   <= '0;
            r_phase  <= 1'b0;
            r_in_pkt <= 1'b0;
        end else begin
            r_side.valid <= bus.valid_i;
            if (bus.valid_i) begin
                r_words      <= w_words;
                r_side.first <= w_first;
                r_side.last  <= bus.last_i;
                r_side.phase <= w_phase_in;
                r_side.seed  <= bus.seed_i;
                r_phase      <= w_phase_in ^ bus.nbytes_i[0];
                r_in_pkt     <= !bus.last_i;
            end
        end
    end

    csum_tree #(
        .WORDS (WORDS)
    ) u_tree (
        .clk      (CLK_i),
        .rst_n    (reset_n_i),
        .words    (r_words),
        .side_in  (r_side),
        .sum      (w_sum),
        .side_out (w_side)
    );

    // A beat starting at an odd byte offset lands in the opposite byte lanes.
    assign w_beat = w_side.phase ? bswap16(w_sum) : w_sum;

    always_ff @(posedge CLK_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_acc      <= '0;
            r_acc_done <= 1'b0;
        end else begin
            r_acc_done <= w_side.valid & w_side.last;
            if (w_side.valid)
                r_acc <= ocadd16(w_side.first ? w_side.seed : r_acc, w_beat);
        end
    end

`ifdef CSUM_ZERO_SUBST_EN
    assign w_csum = (r_acc == 16'hFFFF) ? 16'hFFFF : ~r_acc;
`else
    assign w_csum = ~r_acc;
`endif

    always_ff @(posedge CLK_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.csum_o       <= '0;
            bus.csum_valid_o <= 1'b0;
        end else begin
            bus.csum_valid_o <= r_acc_done;
            if (r_acc_done) bus.csum_o <= w_csum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csum_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_csum_stream
// Brief    : Scoreboard bench for csum_stream at BYTES=4 and BYTES=20.
// Revision : 1.0
// ============================================================================
module tb_csum_stream;

    logic CLK_i     = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    csum_stream_if #(.BYTES(4))  bus4  ();
    csum_stream_if #(.BYTES(20)) bus20 ();

    csum_stream #(.BYTES(4)) u_dut4 (
        .CLK_i     (CLK_i),
        .reset_n_i (reset_n_i),
        .bus       (bus4)
    );

    csum_stream #(.BYTES(20)) u_dut20 (
        .CLK_i     (CLK_i),
        .reset_n_i (reset_n_i),
        .bus       (bus20)
    );

    typedef struct {
        logic [15:0] csum;
        int          due;
    } exp_t;

    localparam logic [159:0] HDR = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
    localparam int LAT4  = 3;
    localparam int LAT20 = 6;

    exp_t        q4[$];
    exp_t        q20[$];
    exp_t        e4;
    exp_t        e20;
    logic [7:0]  pkt4[$];
    logic [7:0]  pkt20[$];
    logic [15:0] seed4;
    logic [15:0] seed20;
    logic [15:0] last4;
    bit          first4  = 1'b1;
    bit          first20 = 1'b1;
    int          cyc     = 0;
    int          n_chk   = 0;
    int          n_pass  = 0;

    always @(posedge CLK_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_csum(input logic [7:0] q[$], input logic [15:0] seed);
        logic [31:0] s;
        logic [15:0] c;
        s = {16'd0, seed};
        for (int i = 0; i < q.size(); i += 2)
            s += {16'd0, q[i], ((i + 1 < q.size()) ? q[i+1] : 8'h00)};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        c = ~s[15:0];
`ifdef CSUM_ZERO_SUBST_EN
        if (c == 16'h0000) c = 16'hFFFF;
`endif
        return c;
    endfunction

    // Lanes beyond n carry random garbage that the DUT must ignore.
    task automatic beat(input bit w20, input logic [159:0] d, input int n,
                        input bit last, input logic [15:0] seed);
        logic [7:0] lane;
        @(negedge CLK_i);
        if (w20) begin
            if (first20) begin pkt20.delete(); seed20 = seed; end
            for (int i = 0; i < 20; i++) begin
                lane = (i < n) ? d[159-8*i -: 8] : 8'($urandom);
                bus20.data_i[i] = lane;
                if (i < n) pkt20.push_back(lane);
            end
            bus20.nbytes_i = n[5:0];
            bus20.seed_i   = first20 ? seed : 16'($urandom);
            bus20.valid_i  = 1'b1;
            bus20.last_i   = last;
            if (last) q20.push_back('{csum: ref_csum(pkt20, seed20), due: cyc + 1 + LAT20});
            first20 = last;
        end else begin
            if (first4) begin pkt4.delete(); seed4 = seed; end
            for (int i = 0; i < 4; i++) begin
                lane = (i < n) ? d[159-8*i -: 8] : 8'($urandom);
                bus4.data_i[i] = lane;
                if (i < n) pkt4.push_back(lane);
            end
            bus4.nbytes_i = n[2:0];
            bus4.seed_i   = first4 ? seed : 16'($urandom);
            bus4.valid_i  = 1'b1;
            bus4.last_i   = last;
            if (last) begin
                last4 = ref_csum(pkt4, seed4);
                q4.push_back('{csum: last4, due: cyc + 1 + LAT4});
            end
            first4 = last;
        end
    endtask

    task automatic idle();
        @(negedge CLK_i);
        bus4.valid_i  = 1'b0;
        bus20.valid_i = 1'b0;
    endtask

    task automatic drain();
        repeat (10) @(negedge CLK_i);
    endtask

    task automatic send_hdr4(input int sz[$], input logic [15:0] seed);
        int off;
        off = 0;
        for (int k = 0; k < sz.size(); k++) begin
            beat(1'b0, HDR << (8 * off), sz[k], k == sz.size() - 1, seed);
            off += sz[k];
        end
    endtask

    always @(negedge CLK_i) begin
        if (bus4.csum_valid_o === 1'b1) begin
            if (q4.size() == 0) chk("pending4", 32'(q4.size()), 32'd1);
            else begin
                e4 = q4.pop_front();
                chk("csum4", 32'(bus4.csum_o), 32'(e4.csum));
                chk("lat4", 32'(cyc), 32'(e4.due));
            end
        end
        if (bus20.csum_valid_o === 1'b1) begin
            if (q20.size() == 0) chk("pending20", 32'(q20.size()), 32'd1);
            else begin
                e20 = q20.pop_front();
                chk("csum20", 32'(bus20.csum_o), 32'(e20.csum));
                chk("lat20", 32'(cyc), 32'(e20.due));
            end
        end
    end

    initial begin
        int sz[$];
        int nb;
        for (int i = 0; i < 4; i++)  bus4.data_i[i]  = 8'h00;
        for (int i = 0; i < 20; i++) bus20.data_i[i] = 8'h00;
        bus4.nbytes_i = '0;  bus4.valid_i = 1'b0;  bus4.last_i = 1'b0;  bus4.seed_i = '0;
        bus20.nbytes_i = '0; bus20.valid_i = 1'b0; bus20.last_i = 1'b0; bus20.seed_i = '0;

        repeat (3) @(negedge CLK_i);
        chk("rst_csum4",   32'(bus4.csum_o),        32'd0);
        chk("rst_valid4",  32'(bus4.csum_valid_o),  32'd0);
        chk("rst_csum20",  32'(bus20.csum_o),       32'd0);
        chk("rst_valid20", 32'(bus20.csum_valid_o), 32'd0);
        reset_n_i = 1'b1;
        @(negedge CLK_i);

        // Full header in one 20-lane beat.
        beat(1'b1, HDR, 20, 1'b1, 16'h0000);
        idle(); drain();

        sz = '{4, 4, 4, 4, 4};
        send_hdr4(sz, 16'h0000);
        idle(); drain();

        // Reset after two of five beats; the partial packet must vanish.
        beat(1'b0, HDR, 4, 1'b0, 16'h0000);
        beat(1'b0, HDR << 32, 4, 1'b0, 16'h0000);
        @(negedge CLK_i);
        reset_n_i = 1'b0;
        bus4.valid_i = 1'b0;
        pkt4.delete();
        first4 = 1'b1;
        @(negedge CLK_i);
        chk("midrst_csum4",  32'(bus4.csum_o),        32'd0);
        chk("midrst_valid4", 32'(bus4.csum_valid_o),  32'd0);
        chk("midrst_csum20", 32'(bus20.csum_o),       32'd0);
        repeat (8) @(negedge CLK_i);
        chk("midrst_hold4",  32'(bus4.csum_valid_o),  32'd0);
        reset_n_i = 1'b1;
        sz = '{4, 4, 4, 4, 4};
        send_hdr4(sz, 16'h0000);
        idle(); drain();

        // Odd byte counts exercise the phase swap.
        sz = '{3, 3, 3, 3, 3, 3, 2};
        send_hdr4(sz, 16'h0000);
        idle(); drain();

        // Seeded one-beat packet, then a zero-result packet with no bubble.
        beat(1'b0, 160'd0, 2, 1'b1, 16'h1234);
        beat(1'b0, {16'hFFFF, 144'd0}, 2, 1'b1, 16'h0000);
        idle(); drain();

        // Empty beats mid-packet and as the closing beat.
        sz = '{4, 0, 4, 4, 4, 4, 0};
        send_hdr4(sz, 16'h0000);
        idle(); drain();
        chk("hold4", 32'(bus4.csum_o), 32'(last4));

        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 6; p++) begin
                nb = $urandom_range(1, 4);
                for (int k = 0; k < nb; k++)
                    beat(b == 1, {$urandom, $urandom, $urandom, $urandom, $urandom},
                         $urandom_range(0, (b == 1) ? 20 : 4), k == nb - 1, 16'($urandom));
            end
            idle(); drain();
        end

        drain();
        chk("left4",  32'(q4.size()),  32'd0);
        chk("left20", 32'(q20.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csum_stream.md
# csum_stream

Streaming, parametrised successor to the single-cycle IP header checksum engine. Computes the 16-bit ones-complement Internet checksum over a packet delivered as a byte stream of up to BYTES lanes per beat, with arbitrary per-beat byte counts, a 16-bit seed for UDP/TCP pseudo-headers, and back-to-back packets. Sits between the UDP/IP framer and the transmit MAC path. It also checks received datagrams in the receive parser.

## Interface
- BYTES, 20: lanes per beat; even, 2..32; lane 0 is the most significant byte on the wire.
- CLK_i  in  1  clock; all logic rises on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_i  in  [7:0] x BYTES  beat payload, unpacked array, data_i[0] first on the wire.
- nbytes_i  in  $clog2(BYTES)+1  number of valid lanes, always a prefix (lanes 0..nbytes_i-1); 0..BYTES.
- valid_i  in  1  beat qualifier; there is no backpressure, so every valid beat is consumed.
- last_i  in  1  final beat of the packet; sampled only with valid_i.
- seed_i  in  16  initial sum (pseudo-header partial); sampled on the first beat of a packet.
- csum_o  out  16  inverted folded checksum.
- csum_valid_o  out  1  one-cycle pulse; csum_o is valid for the packet just completed.

## Operation
- First beat: the first valid beat after reset, or the first valid beat after a beat with last_i.
- Invalid lanes (index >= nbytes_i) are forced to 8'h00 before summation.
- Beat sum: lanes are paired into BYTES/2 big-endian words, then reduced with end-around-carry addition: s = a+b; r = s[15:0]+s[16].
- Phase bit: tracks whether the running stream is at an odd byte offset.
  - Cleared on each first beat.
  - Toggled after every beat with odd nbytes_i.
  - A beat entering with phase=1 has its beat sum byte-swapped ({s[7:0],s[15:8]}) before accumulation.
- Accumulator:
  - First beat: acc <= seed_i (+) beatsum.
  - Other beats: acc <= acc (+) beatsum, where (+) is end-around-carry addition.
- Final stage: csum_o <= ~acc.
- A beat with nbytes_i=0: contributes 0 and leaves phase unchanged. If last_i is set, it still closes the packet.
- Back-to-back packets: a first beat may immediately follow a last beat with no bubble. Per-packet state (phase, first flag, seed) travels down the pipeline with each beat, so packets never mix.
- Reset asynchronously clears all pipeline valids, the accumulator and phase. After reset: csum_o=16'h0000, csum_valid_o=0.
- Reset mid-packet discards the partial packet; no csum_valid_o is produced for it.
- csum_o holds its value until the next csum_valid_o.

## Timing
- Adder tree: registered at every level, depth T = $clog2(BYTES/2); T=0 when BYTES=2.
- Latency: csum_valid_o rises exactly L = T+2 cycles after the posedge that samples valid_i&last_i (tree + accumulator + final stage).
  - BYTES=20 gives L=6; BYTES=4 gives L=3.
- Throughput: one beat per cycle, sustained, including across packet boundaries.
- Packets of one beat (first and last on the same beat) are supported. Two consecutive one-beat packets give two csum_valid_o pulses on consecutive cycles.

## Configuration
- CSUM_ZERO_SUBST_EN defined: a computed checksum of 16'h0000 is output as 16'hFFFF (UDP transmit rule, RFC 768).
- CSUM_ZERO_SUBST_EN undefined: the raw inverted sum is output; 16'h0000 is possible.
- Latency is unchanged in both cases.

## Structure
- Package csum_pkg holds:
  - function ocadd16 (end-around-carry add);
  - function bswap16;
  - function csum_latency(BYTES), returning T+2;
  - typedef csum_t (logic [15:0]).
- Sub-module csum_tree: pipelined end-around-carry adder tree.
  - Parameter WORDS (= BYTES/2).
  - Carries a sideband (valid, first, last, phase, seed) alongside the data.
- csum_stream contains lane masking, phase tracking, the accumulator and the output stage.

## Test plan
- BYTES=20, one beat 4500 0073 0000 4000 4011 0000 c0a8 0001 c0a8 00c7, nbytes=20, seed 0, last -> csum_o=16'hB861, pulse 6 cycles later.
- BYTES=4, same header as 5 full beats -> 16'hB861, pulse 3 cycles after the last beat.
- BYTES=4, same header with nbytes sequence 3,3,3,3,3,3,2 (odd phase path) -> 16'hB861.
- Seed 16'h1234, one beat data 0000, last -> 16'hEDCB. Immediately followed by a packet with seed 0 and data FFFF -> 16'h0000 without CSUM_ZERO_SUBST_EN, 16'hFFFF with it. Pulses arrive on consecutive cycles.
- Drive reset_n_i low mid-packet (after 2 of 5 beats), then resend the full header -> exactly one pulse, 16'hB861. Outputs read 0 during reset.
- Beat with nbytes=0 inserted between beats, and an nbytes=0 last beat -> result unchanged from the reference packet, and the pulse still fires.
